// File: rtl/pipeline_pkg.sv
// Shared types for the RV32IM pipeline: datapath typedefs, ALU op encoding,
// iterative mul/div FSM states and the execute->memory register layout.
package pipeline_pkg;

  typedef logic [31:0] Data;
  typedef logic [4:0]  RegId;
  typedef logic        Bool;
  typedef logic [63:0] DWord;

  localparam Bool TRUE  = 1'b1;
  localparam Bool FALSE = 1'b0;

  localparam Data DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
  localparam int  ITER_COUNT    = 32;

  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } AluOp;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_BUSY,
    MD_DONE
  } MulDivState;

  // Execute -> memory pipeline register
  typedef struct packed {
    Data  alu_res;
    Data  rs2_val;
    RegId rd_idx;
    Bool  mem_load_enable;
    Bool  mem_store_enable;
    Bool  reg_write_enable;
  } ExMemReg;

  function automatic Bool is_muldiv(input AluOp op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
                      OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic Bool is_div(input AluOp op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Iterative RV32M unit: 32-step shift-add multiply / restoring divide on operand
// magnitudes, with sign fix-up applied in the DONE cycle.
module mul_div_unit
  import pipeline_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  AluOp       op,
  input  Data        a,
  input  Data        b,
  output logic       busy,
  output logic       done,
  output Data        result,
  output MulDivState state
);

  MulDivState  next_state;
  logic [4:0]  cnt;
  AluOp        op_q;
  Bool         neg_res;
  Bool         neg_rem;
  Bool         b_zero;
  Data         mag_d;
  Data         hi;
  Data         lo;

  Bool         a_signed;
  Bool         b_signed;
  Data         mag_a_in;
  Data         mag_b_in;
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  Data         div_diff;
  Bool         div_ge;
  DWord        prod_fix;
  Data         quot;
  Data         rem;

  always_comb begin
    a_signed = op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    b_signed = op inside {OP_MULH, OP_DIV, OP_REM};
    mag_a_in = (a_signed && a[31]) ? -a : a;
    mag_b_in = (b_signed && b[31]) ? -b : b;
  end

  // hi:lo is the running product for multiply, remainder:quotient for divide
  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, mag_d} : 33'd0);
    div_shift = {hi, lo[31]};
    div_ge    = div_shift >= {1'b0, mag_d};
    div_diff  = div_shift[31:0] - mag_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= MD_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    busy       = (state != MD_IDLE);
    done       = (state == MD_DONE);
    case (state)
      MD_IDLE: if (start) next_state = MD_BUSY;
      MD_BUSY: if (cnt == 5'(ITER_COUNT - 1)) next_state = MD_DONE;
      MD_DONE: next_state = MD_IDLE;
      default: next_state = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      op_q    <= OP_MUL;
      neg_res <= FALSE;
      neg_rem <= FALSE;
      b_zero  <= FALSE;
      mag_d   <= '0;
      hi      <= '0;
      lo      <= '0;
    end else if (start && state == MD_IDLE) begin
      cnt     <= '0;
      op_q    <= op;
      neg_res <= (a_signed & a[31]) ^ (b_signed & b[31]);
      neg_rem <= a_signed & a[31];
      b_zero  <= (b == '0);
      hi      <= '0;
      mag_d   <= is_div(op) ? mag_b_in : mag_a_in;
      lo      <= is_div(op) ? mag_a_in : mag_b_in;
    end else if (state == MD_BUSY) begin
      cnt <= cnt + 5'd1;
      if (is_div(op_q)) begin
        hi <= div_ge ? div_diff : div_shift[31:0];
        lo <= {lo[30:0], div_ge};
      end else begin
        hi <= mul_sum[32:1];
        lo <= {mul_sum[0], lo[31:1]};
      end
    end
  end

  // A zero divisor leaves remainder == |dividend|, so only the quotient needs a special case
  always_comb begin
    prod_fix = neg_res ? -{hi, lo} : {hi, lo};
    quot     = b_zero ? DIV_BY_ZERO_Q : (neg_res ? -lo : lo);
    rem      = neg_rem ? -hi : hi;
    case (op_q)
      OP_MUL:                      result = prod_fix[31:0];
      OP_MULH, OP_MULHSU, OP_MULHU: result = prod_fix[63:32];
      OP_DIV, OP_DIVU:             result = quot;
      OP_REM, OP_REMU:             result = rem;
      default:                     result = '0;
    endcase
  end

endmodule

// File: rtl/stage_3_execute.sv
// RV32IM execute stage: single-cycle ALU, operand mux, iterative mul/div with
// upstream stall, and the registered execute->memory outputs.
module stage_3_execute
  import pipeline_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  AluOp        alu_op,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  input  logic [31:0] imm,
  input  logic        use_imm,
  input  logic [4:0]  rd_idx,
  input  logic        mem_load_enable,
  input  logic        mem_store_enable,
  input  logic        reg_write_enable,
  output logic        stall_out,
  output logic [31:0] alu_res_out,
  output logic [31:0] rs2_val_out,
  output logic [4:0]  rd_idx_out,
  output logic        mem_load_enable_out,
  output logic        mem_store_enable_out,
  output logic        reg_write_enable_out
);

  Data        op_b;
  Data        alu_val;
  Bool        md_op;
  Bool        md_start;
  Bool        md_busy;
  Bool        md_done;
  Data        md_result;
  MulDivState md_state;
  ExMemReg    cap_q;
  ExMemReg    out_q;
  ExMemReg    out_d;

  assign op_b      = use_imm ? imm : rs2_val;
  assign md_op     = in_valid & is_muldiv(alu_op);
  assign md_start  = md_op & ~md_busy;
  // Held-input protocol: stall_out high means the inputs stay frozen; it drops
  // in DONE so upstream advances on the same edge that registers the result.
  assign stall_out = md_op & (md_state != MD_DONE);

  mul_div_unit u_mul_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (md_start),
    .op     (alu_op),
    .a      (rs1_val),
    .b      (op_b),
    .busy   (md_busy),
    .done   (md_done),
    .result (md_result),
    .state  (md_state)
  );

  always_comb begin
    case (alu_op)
      OP_ADD:  alu_val = rs1_val + op_b;
      OP_SUB:  alu_val = rs1_val - op_b;
      OP_SLL:  alu_val = rs1_val << op_b[4:0];
      OP_SLT:  alu_val = {31'b0, $signed(rs1_val) < $signed(op_b)};
      OP_SLTU: alu_val = {31'b0, rs1_val < op_b};
      OP_XOR:  alu_val = rs1_val ^ op_b;
      OP_SRL:  alu_val = rs1_val >> op_b[4:0];
      OP_SRA:  alu_val = Data'($signed(rs1_val) >>> op_b[4:0]);
      OP_OR:   alu_val = rs1_val | op_b;
      OP_AND:  alu_val = rs1_val & op_b;
      default: alu_val = '0;
    endcase
    if (mem_load_enable || mem_store_enable) alu_val = rs1_val + imm;
  end

  always_comb begin
    out_d = '0;
    if (md_done) begin
      out_d         = cap_q;
      out_d.alu_res = md_result;
    end else if (in_valid && !md_busy && !md_op) begin
      out_d = '{alu_res: alu_val, rs2_val: rs2_val, rd_idx: rd_idx,
                mem_load_enable: mem_load_enable, mem_store_enable: mem_store_enable,
                reg_write_enable: reg_write_enable};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
      cap_q <= '0;
    end else begin
      out_q <= out_d;
      if (md_start) begin
        cap_q <= '{alu_res: '0, rs2_val: rs2_val, rd_idx: rd_idx,
                   mem_load_enable: mem_load_enable, mem_store_enable: mem_store_enable,
                   reg_write_enable: reg_write_enable};
      end
    end
  end

  assign alu_res_out          = out_q.alu_res;
  assign rs2_val_out          = out_q.rs2_val;
  assign rd_idx_out           = out_q.rd_idx;
  assign mem_load_enable_out  = out_q.mem_load_enable;
  assign mem_store_enable_out = out_q.mem_store_enable;
  assign reg_write_enable_out = out_q.reg_write_enable;

endmodule

// File: tb/tb_stage_3_execute.sv
// Bench for stage_3_execute: ALU vector table, M-op corner table with latency
// and bubble counting, mid-op reset, and random ops against an arithmetic model.
module tb_stage_3_execute;
  import pipeline_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  AluOp        alu_op;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [31:0] imm;
  logic        use_imm;
  logic [4:0]  rd_idx;
  logic        mem_load_enable;
  logic        mem_store_enable;
  logic        reg_write_enable;
  logic        stall_out;
  logic [31:0] alu_res_out;
  logic [31:0] rs2_val_out;
  logic [4:0]  rd_idx_out;
  logic        mem_load_enable_out;
  logic        mem_store_enable_out;
  logic        reg_write_enable_out;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    AluOp        op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic        use_imm;
    logic [4:0]  rd;
    logic        ld;
    logic        st;
    logic        we;
    logic [31:0] exp;
  } vec_t;

  vec_t alu_vecs[12];
  vec_t md_vecs[8];

  stage_3_execute dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .in_valid             (in_valid),
    .alu_op               (alu_op),
    .rs1_val              (rs1_val),
    .rs2_val              (rs2_val),
    .imm                  (imm),
    .use_imm              (use_imm),
    .rd_idx               (rd_idx),
    .mem_load_enable      (mem_load_enable),
    .mem_store_enable     (mem_store_enable),
    .reg_write_enable     (reg_write_enable),
    .stall_out            (stall_out),
    .alu_res_out          (alu_res_out),
    .rs2_val_out          (rs2_val_out),
    .rd_idx_out           (rd_idx_out),
    .mem_load_enable_out  (mem_load_enable_out),
    .mem_store_enable_out (mem_store_enable_out),
    .reg_write_enable_out (reg_write_enable_out)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [79:0] out_bundle();
    return {8'h0, alu_res_out, rs2_val_out, rd_idx_out,
            mem_load_enable_out, mem_store_enable_out, reg_write_enable_out};
  endfunction

  // Reference model: RISC-V semantics from plain integer arithmetic
  function automatic logic [31:0] model(input AluOp op, input logic [31:0] a, input logic [31:0] b);
    longint      sa;
    longint      sb;
    logic [63:0] p;
    logic [4:0]  sh;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    sh  = b[4:0];
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      OP_ADD:    return a + b;
      OP_SUB:    return a - b;
      OP_SLL:    return a << sh;
      OP_SLT:    return (sa < sb) ? 32'd1 : 32'd0;
      OP_SLTU:   return (a < b) ? 32'd1 : 32'd0;
      OP_XOR:    return a ^ b;
      OP_SRL:    return a >> sh;
      OP_SRA:    return 32'(sa >>> sh);
      OP_OR:     return a | b;
      OP_AND:    return a & b;
      OP_MUL:    begin p = 64'(sa * sb); return p[31:0]; end
      OP_MULH:   begin p = 64'(sa * sb); return p[63:32]; end
      OP_MULHSU: begin p = 64'(sa * longint'({32'b0, b})); return p[63:32]; end
      OP_MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      OP_DIV:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
      OP_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REM:    return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
      OP_REMU:   return (b == 0) ? a : a % b;
      default:   return 32'h0;
    endcase
  endfunction

  // driver tasks
  task automatic drive(input logic v, input AluOp op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] im, input logic ui, input logic [4:0] rd,
                       input logic ld, input logic st, input logic we);
    in_valid         = v;
    alu_op           = op;
    rs1_val          = a;
    rs2_val          = b;
    imm              = im;
    use_imm          = ui;
    rd_idx           = rd;
    mem_load_enable  = ld;
    mem_store_enable = st;
    reg_write_enable = we;
  endtask

  task automatic drive_idle();
    drive(1'b0, OP_ADD, 32'h1234_5678, 32'h9ABC_DEF0, 32'h55, 1'b1, 5'd7, 1'b1, 1'b1, 1'b1);
  endtask

  // Issue one M-op, hold it while stalled, count stall cycles and bubbles, check result
  task automatic run_mop(input string name, input AluOp op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
    int stall_cnt;
    int bub_cnt;
    stall_cnt = 0;
    bub_cnt   = 0;
    drive(1'b1, op, a, b, 32'h0, 1'b0, rd, 1'b0, 1'b0, 1'b1);
    #1;
    for (int c = 0; c < 40; c++) begin
      if (!stall_out) break;
      stall_cnt++;
      tick();
      if (out_bundle() == 80'h0) bub_cnt++;
    end
    check({name, " stall_cycles"}, 80'(stall_cnt), 80'd33);
    check({name, " bubbles"}, 80'(bub_cnt), 80'd33);
    tick();
    check({name, " result"}, 80'(alu_res_out), 80'(exp));
    check({name, " rd/we"}, {74'h0, rd_idx_out, reg_write_enable_out}, {74'h0, rd, 1'b1});
  endtask

  initial begin
    alu_vecs[0]  = '{OP_ADD,  32'd5,          32'd0,          32'hFFFF_FFF9, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE};
    alu_vecs[1]  = '{OP_SRA,  32'h8000_0000, 32'h24,         32'h0,         1'b0, 5'd5, 1'b0, 1'b0, 1'b1, 32'hF800_0000};
    alu_vecs[2]  = '{OP_SUB,  32'd10,         32'd3,          32'h0,         1'b0, 5'd4, 1'b0, 1'b0, 1'b1, 32'd7};
    alu_vecs[3]  = '{OP_SLL,  32'd1,          32'd0,          32'd31,        1'b1, 5'd6, 1'b0, 1'b0, 1'b1, 32'h8000_0000};
    alu_vecs[4]  = '{OP_SLT,  32'hFFFF_FFFF, 32'd1,          32'h0,         1'b0, 5'd8, 1'b0, 1'b0, 1'b1, 32'd1};
    alu_vecs[5]  = '{OP_SLTU, 32'hFFFF_FFFF, 32'd1,          32'h0,         1'b0, 5'd9, 1'b0, 1'b0, 1'b1, 32'd0};
    alu_vecs[6]  = '{OP_XOR,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0,         1'b0, 5'd10, 1'b0, 1'b0, 1'b1, 32'h0FF0_0FF0};
    alu_vecs[7]  = '{OP_SRL,  32'h8000_0000, 32'd4,          32'h0,         1'b0, 5'd11, 1'b0, 1'b0, 1'b1, 32'h0800_0000};
    alu_vecs[8]  = '{OP_OR,   32'h0F,         32'hF0,         32'h0,         1'b0, 5'd12, 1'b0, 1'b0, 1'b1, 32'hFF};
    alu_vecs[9]  = '{OP_AND,  32'hFF,         32'h0F,         32'h0,         1'b0, 5'd13, 1'b0, 1'b0, 1'b1, 32'h0F};
    alu_vecs[10] = '{OP_ADD,  32'h100,        32'hDEAD_BEEF, 32'd8,         1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 32'h108};
    alu_vecs[11] = '{OP_ADD,  32'h200,        32'h0,          32'hFFFF_FFFC, 1'b1, 5'd14, 1'b1, 1'b0, 1'b1, 32'h1FC};

    md_vecs[0] = '{OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b0, 5'd1,  1'b0, 1'b0, 1'b1, 32'h0};
    md_vecs[1] = '{OP_MUL,  32'd12,        32'hFFFF_FFFD, 32'h0, 1'b0, 5'd2,  1'b0, 1'b0, 1'b1, 32'hFFFF_FFDC};
    md_vecs[2] = '{OP_DIV,  32'd7,         32'd0,         32'h0, 1'b0, 5'd3,  1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF};
    md_vecs[3] = '{OP_REMU, 32'd7,         32'd0,         32'h0, 1'b0, 5'd4,  1'b0, 1'b0, 1'b1, 32'd7};
    md_vecs[4] = '{OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b0, 5'd5,  1'b0, 1'b0, 1'b1, 32'h8000_0000};
    md_vecs[5] = '{OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b0, 5'd6,  1'b0, 1'b0, 1'b1, 32'h0};
    md_vecs[6] = '{OP_REM,  32'hFFFF_FFF9, 32'd2,         32'h0, 1'b0, 5'd7,  1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF};
    md_vecs[7] = '{OP_DIVU, 32'd100,       32'd7,         32'h0, 1'b0, 5'd8,  1'b0, 1'b0, 1'b1, 32'd14};

    // reset with a live instruction on the inputs
    rst_n = 1'b0;
    drive(1'b1, OP_ADD, 32'd1, 32'd2, 32'd3, 1'b0, 5'd9, 1'b0, 1'b0, 1'b1);
    repeat (3) tick();
    check("reset outputs", out_bundle(), 80'h0);
    rst_n = 1'b1;
    drive_idle();
    tick();
    check("idle bubble", out_bundle(), 80'h0);

    // ALU table, one vector per cycle
    foreach (alu_vecs[i]) begin
      drive(1'b1, alu_vecs[i].op, alu_vecs[i].rs1, alu_vecs[i].rs2, alu_vecs[i].imm,
            alu_vecs[i].use_imm, alu_vecs[i].rd, alu_vecs[i].ld, alu_vecs[i].st, alu_vecs[i].we);
      #1;
      check($sformatf("alu[%0d] stall", i), 80'(stall_out), 80'd0);
      @(posedge clk);
      #1;
      check($sformatf("alu[%0d] res", i), 80'(alu_res_out), 80'(alu_vecs[i].exp));
      check($sformatf("alu[%0d] ctl", i),
            {72'h0, rd_idx_out, mem_load_enable_out, mem_store_enable_out, reg_write_enable_out},
            {72'h0, alu_vecs[i].rd, alu_vecs[i].ld, alu_vecs[i].st, alu_vecs[i].we});
    end
    check("store rs2 passthrough", 80'(rs2_val_out), 80'h0);
    drive_idle();
    tick();
    check("bubble after alu", out_bundle(), 80'h0);

    // M-op corners, issued back to back
    foreach (md_vecs[i]) begin
      run_mop($sformatf("md[%0d]", i), md_vecs[i].op, md_vecs[i].rs1, md_vecs[i].rs2,
              md_vecs[i].rd, md_vecs[i].exp);
    end
    // ADD right after the DIVU: accepted at once, then nothing repeats
    drive(1'b1, OP_ADD, 32'd1, 32'd1, 32'h0, 1'b0, 5'd20, 1'b0, 1'b0, 1'b1);
    #1;
    check("b2b add stall", 80'(stall_out), 80'd0);
    @(posedge clk);
    #1;
    check("b2b add res", {43'h0, alu_res_out, rd_idx_out}, {43'h0, 32'd2, 5'd20});
    drive_idle();
    tick();
    check("b2b no dup", out_bundle(), 80'h0);

    // store passthrough standalone
    drive(1'b1, OP_ADD, 32'h100, 32'hDEAD_BEEF, 32'd8, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0);
    tick();
    check("store", out_bundle(), {8'h0, 32'h108, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b1, 1'b0});

    // reset in the middle of a divide (iteration 10)
    drive(1'b1, OP_DIV, 32'd1000, 32'd3, 32'h0, 1'b0, 5'd21, 1'b0, 1'b0, 1'b1);
    repeat (11) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("midop reset outputs", out_bundle(), 80'h0);
    drive_idle();
    tick();
    rst_n = 1'b1;
    tick();
    drive(1'b1, OP_ADD, 32'd40, 32'd2, 32'h0, 1'b0, 5'd22, 1'b0, 1'b0, 1'b1);
    #1;
    check("post reset stall", 80'(stall_out), 80'd0);
    @(posedge clk);
    #1;
    check("post reset add", 80'(alu_res_out), 80'd42);
    run_mop("post reset div", OP_DIV, 32'd1000, 32'd3, 5'd23, 32'd333);

    // random M-ops against the model
    for (int i = 0; i < 6; i++) begin
      AluOp        op;
      logic [31:0] a;
      logic [31:0] b;
      op = AluOp'($urandom_range(int'(OP_MUL), int'(OP_REMU)));
      a  = $urandom();
      b  = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom();
      run_mop($sformatf("rnd_md[%0d]", i), op, a, b, 5'($urandom_range(1, 31)), model(op, a, b));
    end

    // random ALU stream through the scoreboard
    for (int i = 0; i < 150; i++) begin
      AluOp        op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] im;
      logic        ui;
      op = AluOp'($urandom_range(int'(OP_ADD), int'(OP_AND)));
      a  = $urandom();
      b  = $urandom();
      im = $urandom();
      ui = 1'($urandom_range(0, 1));
      drive(1'b1, op, a, b, im, ui, 5'($urandom_range(0, 31)), 1'b0, 1'b0, 1'b1);
      exp_q.push_back(model(op, a, ui ? im : b));
      @(posedge clk);
      #1;
      check($sformatf("rnd_alu[%0d]", i), 80'(alu_res_out), 80'(exp_q.pop_front()));
    end
    drive_idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stage_3_execute.md
# stage_3_execute

Pipeline execute stage of the RV32IM core, between decode/register-read and the memory stage. It computes ALU results for RV32I operations in one cycle and runs RV32M multiply/divide/remainder in an iterative unit. While that unit is busy it stalls upstream. Every output is registered and feeds the memory stage directly: `alu_res`, `rs2_val`, `rd_idx` and the three control enables.

## Interface
Parameters:
- None. Datapath width is fixed by `Data` (32 bits) and `RegId` (5 bits).

Ports (direction, width, meaning):
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  decoded instruction present at inputs.
- `alu_op`  in  `AluOp`  operation select (RV32I ALU ops plus MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
- `rs1_val`  in  32  operand A.
- `rs2_val`  in  32  register operand B; also store data.
- `imm`  in  32  sign-extended immediate.
- `use_imm`  in  1  when high, operand B = `imm`, else `rs2_val`.
- `rd_idx`  in  5  destination register.
- `mem_load_enable`, `mem_store_enable`, `reg_write_enable`  in  1 each  control, passed through.
- `stall_out`  out  1  combinational; upstream must hold all inputs stable while high.
- `alu_res_out`  out  32  registered result or memory address.
- `rs2_val_out`  out  32  registered `rs2_val`.
- `rd_idx_out`  out  5  registered.
- `mem_load_enable_out`, `mem_store_enable_out`, `reg_write_enable_out`  out  1 each  registered.

## Operation
- **Operand B:** `use_imm ? imm : rs2_val`.
- **ALU ops:** ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
  - Shift amount = B[4:0].
  - SLT/SLTU produce 0 or 1.
  - Result registered at the next edge.
- **Bubble:** `in_valid` low outputs a bubble: all enables FALSE, data fields 0.
- **Iterative unit FSM (IDLE, BUSY, DONE):**
  - **IDLE:** M-op present (`in_valid`, M `alu_op`): latch A, B, op and sign flags; clear counter; go to BUSY; emit a bubble.
  - **BUSY:** one iteration per cycle, counter 0..31. Multiply is shift-add on magnitudes; divide is restoring on magnitudes. Counter 31 goes to DONE. Emit bubbles.
  - **DONE:** apply sign fix-up; register the result with the captured `rd_idx` and enables; go to IDLE.
- **`stall_out`** = `in_valid` & M-op & (state != DONE).
- **MULH/MULHSU/MULHU** return bits [63:32] of the 64-bit product; MUL returns bits [31:0]. Signedness per RISC-V.
- **Divide by zero:** DIV/DIVU give 0xFFFF_FFFF; REM/REMU give the dividend.
- **Signed overflow** (0x8000_0000 / -1): DIV gives 0x8000_0000, REM gives 0.
- Special cases still take the full fixed latency.
- **Load/store:** `alu_res_out` = rs1 + imm; enables pass through.

## Timing
- **Reset:** all outputs 0/FALSE; FSM IDLE; counter 0.
- **Reset mid-operation:** abandons the M-op; outputs return to 0 immediately.
- **ALU op latency:** 1 edge, fully pipelined, `stall_out` low.
- **M-op latency:** 34 edges. Acceptance edge E0, iterations E1–E32, result on outputs after E33.
  - `stall_out` is high for 33 cycles, from the cycle the op appears through the DONE cycle exclusive.
  - 33 bubbles reach the memory stage.
- **Next instruction:** one presented in the cycle after E33 is accepted normally.
- **Back-to-back M-ops:** the second starts at the edge after E33, with no extra gap.
- **Input hold:** `in_valid` dropping while BUSY is a protocol violation; the unit completes using latched operands.

## Structure
- **Shared package `pipeline_pkg`:**
  - `AluOp` enum.
  - `is_muldiv(AluOp)` function.
  - `MulDivState` enum.
  - Constants `DIV_BY_ZERO_Q = 'hFFFF_FFFF` and `ITER_COUNT = 32`.
- **Reused types:** `Data`, `RegId`, `Bool` and the register typedefs already in the package.
- **Sub-module `mul_div_unit`:**
  - Contains the FSM, counter, iterative datapath and sign fix-up.
  - Ports `start`, `op`, `a`, `b`, `busy`, `done`, `result`.
  - `stage_3_execute` holds the combinational ALU, operand mux and output registers.

## Test plan
- **ALU path:** ADD rs1=5, imm=-7, `use_imm`=1, rd=3, `reg_write_enable`=1 → next edge `alu_res_out`=0xFFFF_FFFE, `rd_idx_out`=3, `stall_out` low throughout. SRA 0x8000_0000 by B=0x24 → 0xF800_0000 (shift 4).
- **Multiply:** MULH rs1=0xFFFF_FFFF, rs2=0xFFFF_FFFF → `stall_out` high 33 cycles, 33 bubbles, then `alu_res_out`=0. MUL 12×-3 → 0xFFFF_FFDC.
- **Division corner cases:** DIV 7/0 → 0xFFFF_FFFF; REMU 7/0 → 7; DIV 0x8000_0000/-1 → 0x8000_0000; REM same operands → 0; REM -7/2 → -1. All at 34-edge latency.
- **Back-to-back:** DIVU 100/7 followed by ADD 1+1 → 14 after E33, then 2 on the next edge; no instruction lost or duplicated.
- **Reset mid-operation:** assert `rst_n` low at iteration 10 → outputs 0 asynchronously. After release, an ADD completes in 1 edge with `stall_out` low.
- **Store passthrough:** SW rs1=0x100, imm=8, rs2=0xDEAD_BEEF → `alu_res_out`=0x108, `rs2_val_out`=0xDEAD_BEEF, `mem_store_enable_out`=1, `reg_write_enable_out`=0.
